// File: rtl/cy_anim_pkg.sv
// rtl/cy_anim_pkg.sv - shared facing, image index and FSM encodings for the CY sprite sequencer
package cy_anim_pkg;

  typedef enum logic [1:0] {
    FACE_FRONT = 2'd0,
    FACE_BACK  = 2'd1,
    FACE_LEFT  = 2'd2,
    FACE_RIGHT = 2'd3
  } facing_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } anim_state_t;

  localparam logic [3:0] IMG_FRONT_STAND  = 4'd0;
  localparam logic [3:0] IMG_FRONT_WALK_L = 4'd1;
  localparam logic [3:0] IMG_FRONT_WALK_R = 4'd2;
  localparam logic [3:0] IMG_BACK_STAND   = 4'd3;
  localparam logic [3:0] IMG_BACK_WALK_L  = 4'd4;
  localparam logic [3:0] IMG_BACK_WALK_R  = 4'd5;
  localparam logic [3:0] IMG_LEFT_STAND   = 4'd6;
  localparam logic [3:0] IMG_LEFT_WALK    = 4'd7;
  localparam logic [3:0] IMG_RIGHT_STAND  = 4'd8;
  localparam logic [3:0] IMG_RIGHT_WALK   = 4'd9;

  // Front/back cycle walk_L, stand, walk_R, stand; left/right cycle walk, stand.
  // Odd phases are always the stand image.
  function automatic logic [3:0] image_for(input facing_t f, input logic walking,
                                           input logic [1:0] phase);
    logic show_walk;
    logic [3:0] img;
    show_walk = walking & ~phase[0];
    img = IMG_FRONT_STAND;
    case (f)
      FACE_FRONT: img = !show_walk ? IMG_FRONT_STAND :
                        (phase[1] ? IMG_FRONT_WALK_R : IMG_FRONT_WALK_L);
      FACE_BACK:  img = !show_walk ? IMG_BACK_STAND :
                        (phase[1] ? IMG_BACK_WALK_R : IMG_BACK_WALK_L);
      FACE_LEFT:  img = show_walk ? IMG_LEFT_WALK : IMG_LEFT_STAND;
      FACE_RIGHT: img = show_walk ? IMG_RIGHT_WALK : IMG_RIGHT_STAND;
      default:    img = IMG_FRONT_STAND;
    endcase
    return img;
  endfunction

  // Side-facing walks only use phases 0 and 1.
  function automatic logic [1:0] phase_next(input facing_t f, input logic [1:0] phase);
    if (f == FACE_LEFT || f == FACE_RIGHT) begin
      return {1'b0, ~phase[0]};
    end
    return phase + 2'd1;
  endfunction

endpackage

// File: rtl/cy_frame_timer.sv
// rtl/cy_frame_timer.sv - FRAME_DIV enabled-cycle counter producing a phase-advance pulse
module cy_frame_timer #(
  parameter int FRAME_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic phase_adv
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt;

  // Pulse on the enabled cycle that wraps the counter; clear wins over counting.
  assign phase_adv = en & ~clr & (cnt == LAST);

  // Count enabled cycles within the current phase, wrapping at FRAME_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cy_anim_ctrl.sv
// rtl/cy_anim_ctrl.sv - CY sprite movement/walk-animation sequencer; CY_ANIM_DIAG_EN enables diagonal stepping
module cy_anim_ctrl
  import cy_anim_pkg::*;
#(
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 16,
  parameter int H_MIN     = 0,
  parameter int H_MAX     = 620,
  parameter int V_MIN     = 0,
  parameter int V_MAX     = 460,
  parameter int INIT_H    = 310,
  parameter int INIT_V    = 230
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       w,
  input  logic       a,
  input  logic       s,
  input  logic       d,
  input  logic       freeze,
  input  logic       load,
  input  logic [9:0] load_h,
  input  logic [9:0] load_v,
  output logic [9:0] pos_h,
  output logic [9:0] pos_v,
  output logic [3:0] pixel_idx,
  output logic [1:0] facing,
  output logic       moving
);

  // Coordinates are widened to 11 bits so stepping past a bound never wraps.
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] HMIN_W = 11'(H_MIN);
  localparam logic [10:0] HMAX_W = 11'(H_MAX);
  localparam logic [10:0] VMIN_W = 11'(V_MIN);
  localparam logic [10:0] VMAX_W = 11'(V_MAX);

  function automatic logic [9:0] step_dn(input logic [9:0] p, input logic [10:0] lo);
    logic [10:0] p_w;
    p_w = {1'b0, p};
    if (p_w < lo + STEP_W) return 10'(lo);
    return 10'(p_w - STEP_W);
  endfunction

  function automatic logic [9:0] step_up(input logic [9:0] p, input logic [10:0] hi);
    logic [10:0] sum;
    sum = {1'b0, p} + STEP_W;
    if (sum > hi) return 10'(hi);
    return 10'(sum);
  endfunction

  function automatic logic [9:0] clamp(input logic [9:0] p, input logic [10:0] lo,
                                       input logic [10:0] hi);
    if ({1'b0, p} < lo) return 10'(lo);
    if ({1'b0, p} > hi) return 10'(hi);
    return p;
  endfunction

  anim_state_t state, state_nx;
  facing_t     facing_q, facing_nx, dir;
  logic [1:0]  phase, phase_nx;
  logic [9:0]  h_nx, v_nx;
  logic [3:0]  pixel_nx;
  logic        moving_nx;
  logic        vert, horz, valid, step_h, step_v;
  logic        advance, restart, phase_adv;

  assign facing = facing_q;

  // Decode held keys into a direction; opposing keys cancel, vertical wins.
  always_comb begin
    vert   = w ^ s;
    horz   = a ^ d;
    valid  = vert | horz;
    step_v = vert;
    step_h = 1'b0;
    dir    = FACE_FRONT;
    if (vert) begin
      dir = w ? FACE_BACK : FACE_FRONT;
`ifdef CY_ANIM_DIAG_EN
      step_h = horz;
`endif
    end else if (horz) begin
      step_h = 1'b1;
      dir    = a ? FACE_LEFT : FACE_RIGHT;
    end
  end

  // A walk continues only when the same direction is held in WALK; any other
  // update (start, turn, stop, freeze, load) restarts the animation timing.
  assign advance = en & ~load & ~freeze & valid & (state == ST_WALK) & (dir == facing_q);
  assign restart = (en | load) & ~advance;

  cy_frame_timer #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (advance),
    .clr      (restart),
    .phase_adv(phase_adv)
  );

  // Next-state, position and image selection; load outranks en/freeze/keys.
  always_comb begin
    state_nx  = state;
    facing_nx = facing_q;
    phase_nx  = phase;
    h_nx      = pos_h;
    v_nx      = pos_v;
    if (load) begin
      state_nx = ST_IDLE;
      phase_nx = '0;
      h_nx     = clamp(load_h, HMIN_W, HMAX_W);
      v_nx     = clamp(load_v, VMIN_W, VMAX_W);
    end else if (en) begin
      if (freeze || !valid) begin
        state_nx = ST_IDLE;
        phase_nx = '0;
      end else begin
        state_nx = ST_WALK;
        if (step_v) v_nx = w ? step_dn(pos_v, VMIN_W) : step_up(pos_v, VMAX_W);
        if (step_h) h_nx = a ? step_dn(pos_h, HMIN_W) : step_up(pos_h, HMAX_W);
        if (advance) begin
          if (phase_adv) phase_nx = phase_next(facing_q, phase);
        end else begin
          facing_nx = dir;
          phase_nx  = '0;
        end
      end
    end
    moving_nx = (state_nx == ST_WALK);
    pixel_nx  = image_for(facing_nx, moving_nx, phase_nx);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered outputs; the image is computed from next-state values so it
  // never lags facing/moving by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      facing_q  <= FACE_FRONT;
      phase     <= '0;
      pos_h     <= 10'(INIT_H);
      pos_v     <= 10'(INIT_V);
      pixel_idx <= IMG_FRONT_STAND;
      moving    <= 1'b0;
    end else begin
      facing_q  <= facing_nx;
      phase     <= phase_nx;
      pos_h     <= h_nx;
      pos_v     <= v_nx;
      pixel_idx <= pixel_nx;
      moving    <= moving_nx;
    end
  end

endmodule

// File: tb/tb_cy_anim_ctrl.sv
// tb/tb_cy_anim_ctrl.sv - self-checking bench for cy_anim_ctrl against a behavioural model
module tb_cy_anim_ctrl;

  localparam int STEP      = 1;
  localparam int FRAME_DIV = 16;
  localparam int H_MIN     = 0;
  localparam int H_MAX     = 620;
  localparam int V_MIN     = 0;
  localparam int V_MAX     = 460;
  localparam int INIT_H    = 310;
  localparam int INIT_V    = 230;
`ifdef CY_ANIM_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, w, a, s, d, freeze, load;
  logic [9:0] load_h, load_v, pos_h, pos_v;
  logic [3:0] pixel_idx;
  logic [1:0] facing;
  logic       moving;
  logic [26:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: position, facing, walking flag and enabled cycles since the walk (re)started.
  int mh, mv, mface, mcount;
  bit mwalk;

  always #5 clk = ~clk;

  assign dut_vec = {pos_h, pos_v, pixel_idx, facing, moving};

  cy_anim_ctrl #(
    .STEP(STEP), .FRAME_DIV(FRAME_DIV), .H_MIN(H_MIN), .H_MAX(H_MAX),
    .V_MIN(V_MIN), .V_MAX(V_MAX), .INIT_H(INIT_H), .INIT_V(INIT_V)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .w(w), .a(a), .s(s), .d(d),
    .freeze(freeze), .load(load), .load_h(load_h), .load_v(load_v),
    .pos_h(pos_h), .pos_v(pos_v), .pixel_idx(pixel_idx), .facing(facing), .moving(moving)
  );

  function automatic int stand_of(input int f);
    case (f)
      0: return 0;
      1: return 3;
      2: return 6;
      default: return 8;
    endcase
  endfunction

  function automatic int model_img();
    int ph;
    if (!mwalk) return stand_of(mface);
    if (mface < 2) begin
      ph = (mcount / FRAME_DIV) % 4;
      return (ph == 0) ? stand_of(mface) + 1 : (ph == 2) ? stand_of(mface) + 2 : stand_of(mface);
    end
    ph = (mcount / FRAME_DIV) % 2;
    return (ph == 0) ? stand_of(mface) + 1 : stand_of(mface);
  endfunction

  function automatic logic [26:0] model_vec();
    return {10'(mh), 10'(mv), 4'(model_img()), 2'(mface), mwalk};
  endfunction

  task automatic model_reset();
    mh = INIT_H; mv = INIT_V; mface = 0; mcount = 0; mwalk = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit kw, input bit ka, input bit ks, input bit kd,
                            input bit fr, input bit ld, input int lh, input int lv);
    bit vert, horz;
    int nd;
    vert = kw ^ ks;
    horz = ka ^ kd;
    if (ld) begin
      mh = (lh < H_MIN) ? H_MIN : (lh > H_MAX) ? H_MAX : lh;
      mv = (lv < V_MIN) ? V_MIN : (lv > V_MAX) ? V_MAX : lv;
      mwalk = 1'b0; mcount = 0;
    end else if (e) begin
      if (fr || !(vert || horz)) begin
        mwalk = 1'b0; mcount = 0;
      end else begin
        nd = vert ? (kw ? 1 : 0) : (ka ? 2 : 3);
        if (mwalk && nd == mface) mcount++;
        else begin mface = nd; mcount = 0; end
        mwalk = 1'b1;
        if (vert) mv = kw ? ((mv - STEP < V_MIN) ? V_MIN : mv - STEP)
                          : ((mv + STEP > V_MAX) ? V_MAX : mv + STEP);
        if (horz && (!vert || DIAG)) mh = ka ? ((mh - STEP < H_MIN) ? H_MIN : mh - STEP)
                                             : ((mh + STEP > H_MAX) ? H_MAX : mh + STEP);
      end
    end
  endtask

  task automatic drive(input bit e, input bit kw, input bit ka, input bit ks, input bit kd,
                       input bit fr, input bit ld, input int lh, input int lv);
    en = e; w = kw; a = ka; s = ks; d = kd; freeze = fr; load = ld;
    load_h = 10'(lh); load_v = 10'(lv);
    @(posedge clk);
    model_step(e, kw, ka, ks, kd, fr, ld, lh, lv);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 0; w = 0; a = 0; s = 0; d = 0; freeze = 0; load = 0;
    load_h = '0; load_v = '0;
    #12;
    n_checks++;
    if (dut_vec !== {10'(INIT_H), 10'(INIT_V), 4'd0, 2'd0, 1'b0})
      $display("FAIL reset: got h=%0d v=%0d idx=%0d f=%0d m=%0d want h=%0d v=%0d idx=0 f=0 m=0",
               pos_h, pos_v, pixel_idx, facing, moving, INIT_H, INIT_V);
    else n_pass++;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_walk_right();
    int exp_idx;
    for (int i = 1; i <= 40; i++) begin
      drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
      n_checks++;
      if (dut_vec !== model_vec())
        $display("FAIL walk_right cyc %0d: got %h want %h (h,v,idx,f,m packed)", i, dut_vec, model_vec());
      else n_pass++;
      exp_idx = (i <= 16) ? 9 : (i <= 32) ? 8 : 9;
      n_checks++;
      if (pixel_idx !== 4'(exp_idx))
        $display("FAIL walk_right_idx cyc %0d: got %0d want %0d", i, pixel_idx, exp_idx);
      else n_pass++;
    end
    n_checks++;
    if (pos_h !== 10'd350 || facing !== 2'd3)
      $display("FAIL walk_right_end: got h=%0d f=%0d want h=350 f=3", pos_h, facing);
    else n_pass++;
  endtask

  task automatic test_walk_down();
    int seq [4];
    seq = '{1, 0, 2, 0};
    for (int i = 1; i <= 70; i++) begin
      drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
      n_checks++;
      if (dut_vec !== model_vec() || pixel_idx !== 4'(seq[((i - 1) / 16) % 4]))
        $display("FAIL walk_down cyc %0d: got %h want %h idx want %0d", i, dut_vec, model_vec(),
                 seq[((i - 1) / 16) % 4]);
      else n_pass++;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pixel_idx !== 4'd0 || moving !== 1'b0 || dut_vec !== model_vec())
      $display("FAIL walk_down_release: got idx=%0d m=%0d want idx=0 m=0", pixel_idx, moving);
    else n_pass++;
  endtask

  task automatic test_saturate();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 230);
    for (int i = 1; i <= 40; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (dut_vec !== model_vec() || pos_h !== 10'd0 ||
          pixel_idx !== ((((i - 1) / 16) % 2 == 1) ? 4'd6 : 4'd7))
        $display("FAIL saturate_low cyc %0d: got h=%0d idx=%0d vec %h want h=0 vec %h", i, pos_h,
                 pixel_idx, dut_vec, model_vec());
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0, 0, 1, 619, 458);
    for (int i = 1; i <= 5; i++) drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
    n_checks++;
    if (pos_v !== 10'd460 || dut_vec !== model_vec())
      $display("FAIL saturate_high: got v=%0d vec %h want v=460 vec %h", pos_v, dut_vec, model_vec());
    else n_pass++;
  endtask

  task automatic test_priority();
    drive(0, 0, 0, 0, 0, 0, 1, 300, 200);
    for (int i = 1; i <= 5; i++) drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
    n_checks++;
    if (pos_h !== 10'd305 || pos_v !== 10'd200 || facing !== 2'd3 || dut_vec !== model_vec())
      $display("FAIL priority_wsd: got h=%0d v=%0d f=%0d want h=305 v=200 f=3", pos_h, pos_v, facing);
    else n_pass++;
`ifdef CY_ANIM_DIAG_EN
    for (int i = 1; i <= 5; i++) drive(1, 1, 0, 0, 1, 0, 0, 0, 0);
    n_checks++;
    if (pos_h !== 10'd310 || pos_v !== 10'd195 || facing !== 2'd1 || dut_vec !== model_vec())
      $display("FAIL diag_wd: got h=%0d v=%0d f=%0d want h=310 v=195 f=1", pos_h, pos_v, facing);
    else n_pass++;
`endif
  endtask

  task automatic test_load_freeze();
    for (int i = 1; i <= 3; i++) drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 700, 100);
    n_checks++;
    if (pos_h !== 10'd620 || pos_v !== 10'd100 || moving !== 1'b0 || dut_vec !== model_vec())
      $display("FAIL load_freeze: got h=%0d v=%0d m=%0d want h=620 v=100 m=0", pos_h, pos_v, moving);
    else n_pass++;
    drive(1, 1, 0, 0, 0, 0, 1, 5, 900);
    n_checks++;
    if (pos_h !== 10'd5 || pos_v !== 10'd460 || moving !== 1'b0 || dut_vec !== model_vec())
      $display("FAIL load_over_keys: got h=%0d v=%0d m=%0d want h=5 v=460 m=0", pos_h, pos_v, moving);
    else n_pass++;
  endtask

  task automatic test_freeze_and_gate();
    for (int i = 1; i <= 4; i++) drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut_vec !== model_vec() || moving !== 1'b1 || pixel_idx !== 4'd7)
      $display("FAIL en_gate: got %h want %h", dut_vec, model_vec());
    else n_pass++;
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (dut_vec !== model_vec() || pixel_idx !== 4'd6 || moving !== 1'b0)
      $display("FAIL freeze: got idx=%0d m=%0d vec %h want idx=6 m=0 vec %h", pixel_idx, moving,
               dut_vec, model_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    bit e, kw, ka, ks, kd, fr, ld;
    int lh, lv, fails;
    fails = 0;
    {kw, ka, ks, kd} = 4'($urandom_range(0, 15));
    for (int i = 0; i < 1500; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) {kw, ka, ks, kd} = 4'($urandom_range(0, 15));
      fr = ($urandom_range(0, 49) == 0);
      ld = ($urandom_range(0, 59) == 0);
      lh = $urandom_range(0, 1023);
      lv = $urandom_range(0, 1023);
      drive(e, kw, ka, ks, kd, fr, ld, lh, lv);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        if (fails < 10)
          $display("FAIL random cyc %0d: got %h want %h (h,v,idx,f,m packed)", i, dut_vec, model_vec());
        fails++;
      end else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 5; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== {10'(INIT_H), 10'(INIT_V), 4'd0, 2'd0, 1'b0})
      $display("FAIL async_reset: got h=%0d v=%0d idx=%0d f=%0d m=%0d want h=%0d v=%0d idx=0 f=0 m=0",
               pos_h, pos_v, pixel_idx, facing, moving, INIT_H, INIT_V);
    else n_pass++;
    model_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    n_checks++;
    if (dut_vec !== model_vec())
      $display("FAIL after_reset: got %h want %h", dut_vec, model_vec());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_walk_right();
    test_walk_down();
    test_saturate();
    test_priority();
    test_load_freeze();
    test_freeze_and_gate();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
